// File: rtl/mux4_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux4_arb_pkg
// Shared constants and types for the 4-way round-robin mux arbiter.
//   NUM_REQ  : number of requesters (4)
//   SEL_W    : width of a requester index (2)
//   state_t  : arbiter FSM state (IDLE, GRANT)
//   onehot() : index -> one-hot grant vector
// ----------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// ----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker: returns the first set request bit found
// scanning ptr, ptr+1, ... modulo 4.
//   req   [3:0] in  : request vector
//   ptr   [1:0] in  : index where the scan starts
//   idx   [1:0] out : winning requester (0 when nothing is requested)
//   valid       out : any request present
// ----------------------------------------------------------------------------
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               valid
);

    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // 2-bit add wraps naturally, giving the modulo-4 scan order
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter over 4 requesters that also muxes one data bit from the
// current owner. Two-state FSM (IDLE/GRANT); every release inserts one IDLE
// cycle before the next grant.
//   HOLD_MAX       param : maximum grant length in cycles (1..255), only used
//                          when MUX4_ARB_HOLD_LIMIT_EN is defined
//   clk            in    : rising-edge clock
//   rst_n          in    : synchronous active-low reset
//   req      [3:0] in    : one request bit per requester
//   data_in  [3:0] in    : one data bit per requester
//   gnt      [3:0] out   : registered one-hot grant (or zero)
//   sel      [1:0] out   : registered index of current/last owner
//   busy           out   : high while in GRANT
//   y              out   : registered data_in[sel] while granted, else 0
//   preempt        out   : one-cycle pulse on a forced (hold-limit) release
// Optional feature: define MUX4_ARB_HOLD_LIMIT_EN to enable the hold-limit
// counter and preemption. Without it grants are held until req[sel] drops.
// ----------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               y,
    output logic               preempt
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("mux4_rr_arbiter: HOLD_MAX must be in 1..255");
    end

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [SEL_W-1:0]   ptr_q,   ptr_d;
    logic               y_q,     y_d;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_valid;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    logic [7:0]         cnt_q,     cnt_d;
    logic               preempt_q, preempt_d;
    logic               other_pend;

    // Someone other than the owner is waiting; only then is preemption useful
    assign other_pend = |(req & ~gnt_q);
`endif

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    state_d = GRANT;
                    gnt_d   = onehot(pick_idx);
                    sel_d   = pick_idx;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                    cnt_d   = 8'd1;
`endif
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q + SEL_W'(1);
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                else if (cnt_q == 8'(HOLD_MAX)) begin
                    // Limit reached: yield only if someone else is waiting,
                    // otherwise keep the grant with the counter saturated.
                    if (other_pend) begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        ptr_d     = sel_q + SEL_W'(1);
                        cnt_d     = '0;
                        preempt_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        // y shows the owner's data with one cycle of lag, and only while the
        // grant continues; it reads 0 in every IDLE cycle.
        y_d = ((state_q == GRANT) && (state_d == GRANT)) ? data_in[sel_q] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            y_q     <= 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            cnt_q     <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == GRANT);
    assign y    = y_q;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
    logic       preempt;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expected grant vector per cycle, pushed when stimulus is set
    logic [3:0] exp_q[$];

    mux4_rr_arbiter #(.HOLD_MAX(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .y       (y),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 4'b0000;
        data_in = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = 4'b1111;
        data_in = 4'b1111;
        tick();
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || y !== 1'b0 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b sel=%0d busy=%b y=%b preempt=%b, want 0000/0/0/0/0",
                     gnt, sel, busy, y, preempt);
        end
        req     = 4'b0000;
        data_in = 4'b0000;
        rst_n   = 1'b1;
    endtask

    // All requesters high; each owner drops 2 cycles after its grant
    task automatic test_rotation();
        logic [3:0] e;
        int idx;
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(4'b0001 << (i % 4));
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rot_scoreboard_empty: grant %0d has no expected entry", i);
                e = 4'b0000;
            end else begin
                e = exp_q.pop_front();
            end
            idx = (e[1] ? 1 : 0) + (e[2] ? 2 : 0) + (e[3] ? 3 : 0);
            if (gnt !== e || sel !== 2'(idx) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rot_grant%0d: gnt=%b sel=%0d busy=%b, want %b/%0d/1", i, gnt, sel, busy, e, idx);
            end
            tick();
            n_tests++;
            if (gnt !== e) begin
                n_fail++;
                $display("FAIL rot_hold%0d: gnt=%b want %b", i, gnt, e);
            end
            req[idx] = 1'b0;
            tick();
            n_tests++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rot_idle%0d: gnt=%b busy=%b want 0000/0", i, gnt, busy);
            end
            req[idx] = 1'b1;
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_data_path();
        do_reset();
        req     = 4'b0100;
        data_in = 4'b0100;
        tick();
        n_tests++;
        if (gnt !== 4'b0100 || sel !== 2'd2) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b sel=%0d want 0100/2", gnt, sel);
        end
        tick();
        n_tests++;
        if (y !== 1'b1) begin
            n_fail++;
            $display("FAIL y_follow: y=%b want 1", y);
        end
        data_in = 4'b1011;
        tick();
        n_tests++;
        if (y !== 1'b0) begin
            n_fail++;
            $display("FAIL y_other_bits: y=%b want 0", y);
        end
        // Other req bits change while granted: must be ignored
        req = 4'b1111;
        data_in = 4'b0100;
        tick();
        req = 4'b0101;
        tick();
        n_tests++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || y !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_others: gnt=%b sel=%0d y=%b want 0100/2/1", gnt, sel, y);
        end
        req = 4'b0000;
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || y !== 1'b0 || sel !== 2'd2) begin
            n_fail++;
            $display("FAIL release_idle: gnt=%b y=%b sel=%0d want 0000/0/2", gnt, y, sel);
        end
        // Nothing requested in IDLE: stay idle, sel keeps last owner
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd2) begin
            n_fail++;
            $display("FAIL idle_hold: gnt=%b busy=%b sel=%0d want 0000/0/2", gnt, busy, sel);
        end
        // ptr is now 3; simultaneous 0 and 1 -> 0 wins (scan 3,0,1,2)
        req = 4'b0011;
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL ptr_wrap: gnt=%b sel=%0d want 0001/0", gnt, sel);
        end
        req = 4'b0000;
        data_in = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0010;
        tick();
        n_tests++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL pre_reset_grant: gnt=%b want 0010", gnt);
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: gnt=%b sel=%0d busy=%b want 0000/0/0", gnt, sel, busy);
        end
        rst_n = 1'b1;
        req   = 4'b1010;
        tick();
        n_tests++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            n_fail++;
            $display("FAIL post_reset_pick: gnt=%b sel=%0d want 0010/1", gnt, sel);
        end
        req = 4'b1000;
        tick();
        // Owner 1 released: ptr = 2, so a fresh 1010 goes to 3
        req = 4'b1010;
        tick();
        n_tests++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            n_fail++;
            $display("FAIL ptr_after_release: gnt=%b sel=%0d want 1000/3", gnt, sel);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // Requester that appears and drops while idle without being picked
    task automatic test_drop_in_idle();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        // idle cycle after release; pulse req[2] only between edges
        req = 4'b0100;
        #2;
        req = 4'b0000;
        tick();
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_in_idle: gnt=%b busy=%b want 0000/0", gnt, busy);
        end
    endtask

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    task automatic test_hold_limit();
        logic [3:0] e;
        logic [0:5] exp_pre = 6'b000100;
        do_reset();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0010);
        req = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            tick();
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
            n_tests++;
            if (gnt !== e || preempt !== exp_pre[i]) begin
                n_fail++;
                $display("FAIL hold_limit_c%0d: gnt=%b preempt=%b want %b/%b", i, gnt, preempt, e, exp_pre[i]);
            end
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_hold_alone();
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (gnt !== 4'b0001 || preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_alone_c%0d: gnt=%b preempt=%b want 0001/0", i, gnt, preempt);
            end
        end
        req = 4'b0000;
        tick();
        tick();
    endtask
`else
    task automatic test_no_limit();
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++;
            if (gnt !== 4'b0001 || preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL no_limit_c%0d: gnt=%b preempt=%b want 0001/0", i, gnt, preempt);
            end
        end
        req = 4'b0000;
        tick();
        tick();
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        req     = 4'b0000;
        data_in = 4'b0000;
        test_reset();
        test_rotation();
        test_data_path();
        test_reset_mid_grant();
        test_drop_in_idle();
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        test_hold_limit();
        test_hold_alone();
`else
        test_no_limit();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net: never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, giving the maximum grant length in cycles (legal range 1..255, used only with HOLD_LIMIT_EN).
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits: request, one bit per requester 0..3.
REQ-005 The block SHALL have port data_in, input, 4 bits: data bit per requester, bit i belonging to requester i.
REQ-006 The block SHALL have port gnt, output, 4 bits: registered one-hot grant, or all zero.
REQ-007 The block SHALL have port sel, output, 2 bits: registered index of the current or last owner.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in state GRANT.
REQ-009 The block SHALL have port y, output, 1 bit: registered data_in[sel] while busy, else 0.
REQ-010 The block SHALL have port preempt, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-012 In IDLE with req != 0, the block SHALL pick the first set req bit scanning ptr, ptr+1, ... modulo 4, and at the next edge enter GRANT with gnt one-hot on the winner and sel = winner (1-cycle latency).
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0 and sel holding its last value.
REQ-014 In GRANT, the block SHALL ignore changes on req bits other than req[sel].
REQ-015 In GRANT, when req[sel] is sampled low, the block SHALL go to IDLE at the next edge with gnt = 0 and ptr = sel+1 mod 4.
REQ-016 Each release SHALL produce exactly one IDLE cycle (gnt = 0) before any new grant; no back-to-back grants.
REQ-017 y SHALL be registered data_in[sel] each cycle in GRANT (one-cycle lag from data_in), and 0 in IDLE.
REQ-018 A requester whose req drops in IDLE before being picked SHALL not be granted.
REQ-019 When several req bits rise in the same cycle, the block SHALL resolve them purely by ptr rotation.
REQ-020 gnt SHALL never have more than one bit set.

Reset
REQ-021 When rst_n is low at a clock edge, the block SHALL force state = IDLE, gnt = 0, sel = 0, ptr = 0, busy = 0, y = 0, preempt = 0, and clear the hold counter.
REQ-022 Reset SHALL take priority over all other events, including mid-GRANT; the grant is dropped at that edge.
REQ-023 After reset, with all four req bits high, the block SHALL grant requester 0 first.

Configuration
REQ-024 With macro MUX4_ARB_HOLD_LIMIT_EN defined, a hold counter SHALL load 1 on entry to GRANT and increment each cycle spent in GRANT.
REQ-025 With the macro defined, when count == HOLD_MAX, req[sel] is still high and (req & ~gnt) != 0, the block SHALL go to IDLE at the next edge, set ptr = sel+1, and pulse preempt high for that one cycle.
REQ-026 With the macro defined, at count == HOLD_MAX and no other requester pending, the block SHALL hold the counter saturated and keep the grant.
REQ-027 Without the macro, grants SHALL be held until req[sel] drops, preempt SHALL be tied to 0, HOLD_MAX SHALL be ignored, and no counter logic SHALL exist.

Structure
REQ-028 Package mux4_arb_pkg SHALL hold NUM_REQ = 4, SEL_W = 2 and the state enum type (IDLE, GRANT).
REQ-029 Sub-module rr_pick4 SHALL be combinational, with inputs req[3:0] and ptr[1:0] and outputs idx[1:0] and valid.
REQ-030 The data selection in mux4_rr_arbiter SHALL be inline.

Verification
REQ-031 Reset then req = 1111 held; each owner drops req 2 cycles after its grant -> grant order 0,1,2,3,0; gnt = 0 for exactly one cycle between grants.
REQ-032 Reset; req = 0100 -> gnt = 0100 and sel = 2 one edge later; with data_in = 0100, y = 1 one edge after the grant.
REQ-033 Assert rst_n low while gnt = 0010 -> next edge gnt = 0, sel = 0, busy = 0; then req = 1010 -> gnt = 0010 is not kept, and requester 1 wins only because ptr = 0 scans 0,1,...
REQ-034 With the macro and HOLD_MAX = 3: req = 0011 held -> gnt = 0001 for 3 cycles, preempt pulses 1 cycle, one idle cycle, then gnt = 0010.
REQ-035 With the macro and HOLD_MAX = 3: req = 0001 alone held 10 cycles -> grant kept for the whole run and preempt stays 0.
REQ-036 Without the macro: req = 0011 held 20 cycles -> gnt = 0001 throughout and preempt = 0.
